// File: rtl/bnn_feat_loader.sv
// Stream loader packing feature beats into the BNN feature bus, then returning the class.
// Optional framing check on s_last is enabled by defining BNN_LOADER_LASTCHK_EN.
module bnn_feat_loader #(
  parameter int FEAT_CNT  = 128,
  parameter int FEAT_BITS = 4,
  parameter int CLASS_CNT = 6,
  parameter int INFER_LAT = 48,
  localparam int PW = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [FEAT_BITS-1:0]          s_data,
  input  logic                          s_last,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features,
  input  logic [PW-1:0]                 prediction,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [PW-1:0]                 m_class,
  output logic                          busy,
  output logic                          err
);

  localparam int CW = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int TW = (INFER_LAT > 1) ? $clog2(INFER_LAT) : 1;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(FEAT_CNT - 1);
  localparam logic [TW-1:0] TMR_INIT = TW'(INFER_LAT - 1);

  logic [1:0]                    state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [TW-1:0]                 timer_q, timer_d;
  logic [PW-1:0]                 mcls_q, mcls_d;
  logic                          mvalid_q, mvalid_d;
  logic                          err_q, err_d;
  logic [FEAT_CNT*FEAT_BITS-1:0] feat_q;
  logic                          accept;
  logic                          is_last;
  logic                          frame_err;
  logic                          wr_en;

  assign accept  = s_valid && (state_q == ST_LOAD);
  assign is_last = (cnt_q == CNT_LAST);

`ifdef BNN_LOADER_LASTCHK_EN
  // s_last must coincide exactly with the final slot
  assign frame_err = accept && (s_last != is_last);
`else
  logic unused_last;
  assign unused_last = s_last;
  assign frame_err   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    mcls_d   = mcls_q;
    mvalid_d = mvalid_q;
    err_d    = 1'b0;
    wr_en    = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if (frame_err) begin
            cnt_d = '0;
            err_d = 1'b1;
          end else if (is_last) begin
            cnt_d   = '0;
            timer_d = TMR_INIT;
            state_d = ST_WAIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (timer_q == '0) begin
          mcls_d   = prediction;
          mvalid_d = 1'b1;
          state_d  = ST_DONE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (m_ready) begin
          mvalid_d = 1'b0;
          state_d  = ST_LOAD;
        end
      end
      default: begin
        state_d  = ST_LOAD;
        mvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_LOAD;
      cnt_q    <= '0;
      timer_q  <= '0;
      mcls_q   <= '0;
      mvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      mcls_q   <= mcls_d;
      mvalid_q <= mvalid_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      feat_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < FEAT_CNT; i++) begin
        if (cnt_q == CW'(i)) feat_q[i*FEAT_BITS +: FEAT_BITS] <= s_data;
      end
    end
  end

  assign s_ready  = (state_q == ST_LOAD);
  assign busy     = (state_q == ST_WAIT) || (state_q == ST_DONE);
  assign features = feat_q;
  assign m_valid  = mvalid_q;
  assign m_class  = mcls_q;
  assign err      = err_q;

endmodule

// File: tb/tb_bnn_feat_loader.sv
// Scoreboard bench for bnn_feat_loader: directed samples, stalls, reset abort, framing.
module tb_bnn_feat_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [3:0]   s_data = 4'h0;
  logic         s_last = 1'b0;
  logic [511:0] features;
  logic [2:0]   prediction;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [2:0]   m_class;
  logic         busy;
  logic         err;

  logic [2:0]   pred_drv = 3'd0;
  bit           pred_mode = 1'b0;

  // mode 1: classifier stub answers with bits [2:0] of feature slot 1
  assign prediction = pred_mode ? features[6:4] : pred_drv;

  bnn_feat_loader dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .features   (features),
    .prediction (prediction),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_class    (m_class),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] expq[$];
  int         riseq[$];
  bit         prev_mv  = 1'b0;
  bit         err_seen = 1'b0;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid && !prev_mv) riseq.push_back(cyc);
    prev_mv = m_valid;
    if (err) err_seen = 1'b1;
    if (m_valid && m_ready) begin
      if (expq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got class %0d expected none", m_class);
      end else begin
        check("sb_class", 32'(m_class), 32'(expq.pop_front()));
      end
    end
  end

  task automatic send(input logic [3:0] xr, input bit rnd, input int n,
                      input int last_at, output int e);
    int  i = 0;
    int  g = 0;
    bit  acc;
    e = -1;
    while (i < n && g < 3000) begin
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = 4'(i) ^ xr;
      s_last  = (i == last_at);
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      g++;
      if (acc) begin
        e = cyc;
        i++;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (i < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got %0d beats expected %0d", i, n);
    end
  endtask

  task automatic wait_rise(output int c);
    int g = 0;
    while (riseq.size() == 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (riseq.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL rise_timeout: got no m_valid expected one");
      c = -1000;
    end else begin
      c = riseq.pop_front();
    end
  endtask

  initial begin
    int e, e2, r, r1, bad, acc;

    #12;
    check("rst_features", 32'(|features), 0);
    check("rst_s_ready", 32'(s_ready), 1);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_m_class", 32'(m_class), 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;

    // sample 1: data = i, class 3, consumer not ready
    pred_drv = 3'd3;
    expq.push_back(3'd3);
    send(4'h0, 1'b0, 128, 127, e);
    @(negedge clk);
    check("t1_s_ready_low", 32'(s_ready), 0);
    check("t1_busy", 32'(busy), 1);
    check("t1_slot0", 32'(features[3:0]), 32'h0);
    check("t1_slot127", 32'(features[511:508]), 32'hF);
    wait_rise(r);
    check("t1_latency", r - e, 48);

    // DONE held: prediction moves, beats offered, nothing accepted
    pred_drv = 3'd5;
    s_valid  = 1'b1;
    s_data   = 4'h7;
    bad = 0;
    acc = 0;
    repeat (20) begin
      @(negedge clk);
      if (s_ready) acc++;
      if (!m_valid || m_class !== 3'd3) bad++;
      pred_drv = pred_drv ^ 3'd1;
    end
    check("t2_no_accept", acc, 0);
    check("t2_hold_stable", bad, 0);
    s_valid = 1'b0;
    @(posedge clk) #1 m_ready = 1'b1;
    @(posedge clk) #1 m_ready = 1'b0;
    @(negedge clk);
    check("t2_m_valid_drop", 32'(m_valid), 0);
    check("t2_s_ready_back", 32'(s_ready), 1);
    check("t2_slot127_kept", 32'(features[511:508]), 32'hF);

    // sample 2: random valid gaps, data = i ^ A
    @(posedge clk) #1;
    m_ready  = 1'b1;
    pred_drv = 3'd1;
    expq.push_back(3'd1);
    send(4'hA, 1'b1, 128, 127, e);
    bad = 0;
    for (int i = 0; i < 128; i++)
      if (features[i*4 +: 4] !== (4'(i) ^ 4'hA)) bad++;
    check("t3_slot_order", bad, 0);
    wait_rise(r);
    check("t3_latency", r - e, 48);

    // abort mid-WAIT with timer at 20
    @(posedge clk) #1;
    pred_drv = 3'd2;
    expq.push_back(3'd2);
    send(4'h5, 1'b0, 128, 127, e);
    repeat (27) @(posedge clk);
    #2 rst = 1'b0;
    void'(expq.pop_back());
    #1;
    check("t4_async_features", 32'(|features), 0);
    check("t4_async_m_valid", 32'(m_valid), 0);
    check("t4_async_busy", 32'(busy), 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    expq.push_back(3'd2);
    send(4'h3, 1'b0, 128, 127, e);
    check("t4_slot1_new", 32'(features[7:4]), 32'h2);
    wait_rise(r);
    check("t4_latency", r - e, 48);

    // back-to-back: stub class from slot 1 (1^4=5, 1^2=3)
    @(posedge clk) #1;
    pred_mode = 1'b1;
    expq.push_back(3'd5);
    expq.push_back(3'd3);
    send(4'h4, 1'b0, 128, 127, e);
    send(4'h2, 1'b0, 128, 127, e2);
    wait_rise(r1);
    wait_rise(r);
    check("t5_period", r - r1, 177);
    check("t5_latency2", r - e2, 48);
    pred_mode = 1'b0;

    @(posedge clk) #1;
    err_seen = 1'b0;
    pred_drv = 3'd4;
`ifdef BNN_LOADER_LASTCHK_EN
    send(4'h0, 1'b0, 64, 63, e);
    @(negedge clk);
    check("t6_err_pulse", 32'(err), 1);
    check("t6_not_busy", 32'(busy), 0);
    @(negedge clk);
    check("t6_err_one_cycle", 32'(err), 0);
    repeat (60) @(negedge clk);
    check("t6_no_inference", riseq.size(), 0);
    err_seen = 1'b0;
    @(posedge clk) #1;
    expq.push_back(3'd4);
    send(4'h1, 1'b0, 128, 127, e);
    wait_rise(r);
    check("t6_latency", r - e, 48);
    check("t6_no_err", 32'(err_seen), 0);
`else
    expq.push_back(3'd4);
    send(4'h1, 1'b0, 128, 63, e);
    wait_rise(r);
    check("t6_latency_nolast", r - e, 48);
    check("t6_err_tied", 32'(err_seen), 0);
`endif

    repeat (3) @(negedge clk);
    check("sb_drain", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bnn_feat_loader.md
# bnn_feat_loader

Front-end stream loader for the sequential BNN classifiers (FEAT_CNT features of FEAT_BITS each, CLASS_CNT classes). Accepts one quantised feature per beat on a valid/ready stream, packs them into the flat feature bus that drives the classifier, and holds the bus stable for a fixed inference latency. It then samples the classifier's prediction and returns it on a valid/ready result port. It sits between the sample source (sensor front-end or test harness) and any `*_bnnromesh` top.

## Interface
- FEAT_CNT, 128, features per sample
- FEAT_BITS, 4, bits per feature
- CLASS_CNT, 6, classes; prediction width PW = $clog2(CLASS_CNT)
- INFER_LAT, 48, cycles from bus-complete to prediction sample (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- s_valid  in  1  feature beat valid
- s_ready  out  1  loader accepts beat
- s_data  in  FEAT_BITS  feature value
- s_last  in  1  final beat of sample; used only with BNN_LOADER_LASTCHK_EN
- features  out  FEAT_CNT*FEAT_BITS  to classifier; feature i at bits [i*FEAT_BITS +: FEAT_BITS]
- prediction  in  PW  from classifier
- m_valid  out  1  result valid
- m_ready  in  1  result consumer ready
- m_class  out  PW  captured prediction
- busy  out  1  high in WAIT or DONE
- err  out  1  one-cycle framing-error pulse

## Operation
- States: LOAD, WAIT, DONE. Reset state LOAD.
- Reset values: features=0, m_class=0, m_valid=0, err=0, busy=0, beat counter cnt=0, timer=0. s_ready=1 after reset, since the state is LOAD.
- LOAD:
  - s_ready=1.
  - A beat is accepted when s_valid&&s_ready. It writes s_data into slot cnt of the features register and increments cnt.
  - Accepting the beat with cnt==FEAT_CNT-1 clears cnt to 0, loads timer=INFER_LAT-1, and moves to WAIT.
  - s_valid low stalls the loader with no state change.
- WAIT:
  - s_ready=0 and features are frozen.
  - timer decrements each cycle.
  - In the cycle timer==0, m_class is loaded from prediction, the state moves to DONE, and m_valid rises.
- DONE:
  - m_valid=1 and m_class is held stable until m_ready.
  - On m_valid&&m_ready the loader returns to LOAD, and m_valid drops next cycle.
- features is not cleared between samples. Each slot is overwritten by the next sample's beats.
- cnt is $clog2(FEAT_CNT) bits wide, or 1 bit when FEAT_CNT=1. It never exceeds FEAT_CNT-1.
- Reset asserted mid-sample or mid-inference aborts immediately, and all registers take their reset values.

## Timing
- Beat throughput in LOAD: 1 per cycle. A full sample takes FEAT_CNT accepting cycles.
- Call the edge on which the last beat is accepted edge E.
  - features is complete after E.
  - prediction is sampled on edge E+INFER_LAT.
  - m_valid is high after E+INFER_LAT.
- Minimum sample-to-sample period is FEAT_CNT+INFER_LAT+1 cycles, with m_ready held high.
- m_ready high in the first DONE cycle gives a 1-cycle m_valid pulse.
- s_ready is low for the whole of WAIT and DONE. s_valid during that time is ignored, not buffered.
- err is registered and is high for exactly one cycle, the cycle after the offending beat.

## Configuration
- BNN_LOADER_LASTCHK_EN defined:
  - An accepted beat with s_last=1 and cnt≠FEAT_CNT-1 is an error.
  - An accepted beat with s_last=0 and cnt==FEAT_CNT-1 is also an error.
  - On error: the beat is written, err pulses, cnt clears to 0, and the state stays LOAD. The sample is discarded and no inference runs.
- Macro undefined:
  - s_last is ignored and err is tied 0.
  - Framing is by count only.

## Test plan
- Reset, then stream 128 beats s_data=i[3:0]. Required: features[3:0]=0, features[511:508]=0xF, s_ready drops after beat 127, m_valid rises exactly 48 cycles after the last-beat edge, m_class equals prediction at that edge (drive 3, expect 3).
- Hold m_ready=0 for 20 cycles in DONE while prediction changes. Required: m_class stays 3, m_valid stays high, s_valid beats get no acceptance. Raise m_ready for one cycle: m_valid low next cycle, s_ready high.
- Toggle s_valid randomly (50%) over one sample. Required: exactly 128 accepts, slot order preserved, latency counted from the final accept.
- Assert rst low mid-WAIT (timer=20). Required: features=0, m_valid=0, busy=0 asynchronously. After release, a full new sample runs normally.
- Two back-to-back samples with m_ready=1. Required: second m_valid exactly 128+48+1 cycles after the first.
- With BNN_LOADER_LASTCHK_EN, s_last=1 on beat 63. Required: err one-cycle pulse, no m_valid, next 128-beat sample with s_last on beat 127 classifies normally.
